// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, ex_mem_bus field offsets,
// load-type encodings and the slot state / debug view.
package mem_stage_pkg;

    localparam int EX_MEM_W = 240;
    localparam int MEM_WB_W = 234;
    localparam int MEM_ID_W = 55;
    localparam int CANCEL_W = 2;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    // LSB position of each ex_mem_bus field (MSB-first order: gr_we ... ecode)
    localparam int OFS_GR_WE        = 239;
    localparam int OFS_RES_FROM_MEM = 238;
    localparam int OFS_MEM_TYPE     = 235;
    localparam int OFS_LOW2         = 233;
    localparam int OFS_DEST         = 228;
    localparam int OFS_PC           = 196;
    localparam int OFS_INST         = 164;
    localparam int OFS_RESULT       = 132;
    localparam int OFS_CSR_RE       = 130;
    localparam int OFS_CSR_NUM      = 116;
    localparam int OFS_ERTN         = 51;
    localparam int OFS_EX           = 15;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } slot_state_t;

    typedef struct packed {
        slot_state_t         state;
        logic                buf_vld;
        logic [CANCEL_W-1:0] cancel_cnt;
    } mem_dbg_t;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of the SRAM word and sign- or
// zero-extends it according to the load type.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_low2,
    input  logic [2:0]  mem_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_low2)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_low2[1] ? rdata[31:16] : rdata[15:0];

        case (mem_type)
            MT_B:    result = {{24{byte_sel[7]}}, byte_sel};
            MT_H:    result = {{16{half_sel[15]}}, half_sel};
            MT_BU:   result = {24'b0, byte_sel};
            MT_HU:   result = {16'b0, half_sel};
            MT_W:    result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data_sram response,
// drops responses owed to flushed instructions, and feeds WB and the ID bypass.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    output logic                mem_allowin,
    input  logic                ex_mem_valid,
    input  logic [EX_MEM_W-1:0] ex_mem_bus,
    input  logic                ex_mem_req,
    output logic                mem_wb_valid,
    input  logic                wb_allowin,
    output logic [MEM_WB_W-1:0] mem_wb_bus,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                wb_ex,
    input  logic                ertn_flush,
    output logic                mem_ex,
    output logic                mem_ertn,
    output logic [MEM_ID_W-1:0] mem_id_bus,
    output mem_dbg_t            dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and the
    // receiver's allowin are both high; valid never depends on allowin.

    slot_state_t         state;
    logic [EX_MEM_W-1:0] bus_r;
    logic [31:0]         rdata_buf;
    logic                buf_vld;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic        mem_valid;
    logic        mem_ready_go;
    logic        flush;
    logic        cancel_idle;
    logic        data_take;
    logic        cnt_inc;
    logic        cnt_dec;
    logic        bypass;
    logic        ld_wait;
    logic [31:0] load_data;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign mem_valid    = (state != S_EMPTY);
    assign flush        = wb_ex | ertn_flush;
    assign cancel_idle  = (cancel_cnt == '0);
    assign data_take    = data_sram_data_ok & cancel_idle & (state == S_WAIT);
    assign mem_ready_go = (state != S_WAIT) | (data_sram_data_ok & cancel_idle);
    assign mem_wb_valid = mem_valid & mem_ready_go;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);

    // A flushed WAIT slot still owes a response; a response arriving while the
    // count is non-zero belongs to an older, flushed request.
    assign cnt_inc = flush & (state == S_WAIT) & ~data_take;
    assign cnt_dec = data_sram_data_ok & ~cancel_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_EMPTY;
            buf_vld    <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            if (cnt_inc && !cnt_dec && cancel_cnt != '1)
                cancel_cnt <= cancel_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc)
                cancel_cnt <= cancel_cnt - 1'b1;

            if (flush) begin
                state   <= S_EMPTY;
                buf_vld <= 1'b0;
            end else if (mem_allowin) begin
                state   <= ex_mem_valid ? (ex_mem_req ? S_WAIT : S_READY) : S_EMPTY;
                buf_vld <= 1'b0;
            end else if (data_take) begin
                state   <= S_READY;
                buf_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ex_mem_valid && mem_allowin)
            bus_r <= ex_mem_bus;
        if (data_take)
            rdata_buf <= data_sram_rdata;
    end

    assign load_data = buf_vld ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .rdata     (load_data),
        .addr_low2 (bus_r[OFS_LOW2 +: 2]),
        .mem_type  (bus_r[OFS_MEM_TYPE +: 3]),
        .result    (load_result)
    );

    assign final_result = bus_r[OFS_RES_FROM_MEM] ? load_result : bus_r[OFS_RESULT +: 32];

    assign mem_wb_bus = {bus_r[OFS_GR_WE], bus_r[OFS_DEST +: 5], bus_r[OFS_PC +: 32],
                         bus_r[OFS_INST +: 32], final_result, bus_r[OFS_RESULT-1:0]};

    assign mem_ex   = mem_valid & bus_r[OFS_EX];
    assign mem_ertn = mem_valid & bus_r[OFS_ERTN];
    assign bypass   = mem_valid & bus_r[OFS_GR_WE] & ~bus_r[OFS_EX];
    assign ld_wait  = mem_valid & bus_r[OFS_RES_FROM_MEM] & ~mem_ready_go;

    assign mem_id_bus = {bypass, ld_wait, bus_r[OFS_DEST +: 5], final_result,
                         bus_r[OFS_GR_WE], bus_r[OFS_CSR_RE], bus_r[OFS_CSR_NUM +: 14]};

    assign dbg = '{state: state, buf_vld: buf_vld, cancel_cnt: cancel_cnt};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized single-instruction
// traffic checked against a behavioural load/bus model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_allowin;
    logic         ex_mem_valid;
    logic [239:0] ex_mem_bus;
    logic         ex_mem_req;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [233:0] mem_wb_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_ex;
    logic         ertn_flush;
    logic         mem_ex;
    logic         mem_ertn;
    logic [54:0]  mem_id_bus;
    mem_dbg_t     dbg;

    int total = 0;
    int bad = 0;
    logic [233:0] exp_q[$];

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mem_allowin       (mem_allowin),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_bus        (ex_mem_bus),
        .ex_mem_req        (ex_mem_req),
        .mem_wb_valid      (mem_wb_valid),
        .wb_allowin        (wb_allowin),
        .mem_wb_bus        (mem_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .mem_ex            (mem_ex),
        .mem_ertn          (mem_ertn),
        .mem_id_bus        (mem_id_bus),
        .dbg               (dbg)
    );

    always #5 clk = ~clk;

    wire        id_bypass  = mem_id_bus[54];
    wire        id_ld_wait = mem_id_bus[53];
    wire [31:0] wb_result  = mem_wb_bus[163:132];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [239:0] make_bus(input logic gr_we, input logic rfm, input logic [2:0] mt,
                                              input logic [1:0] low2, input logic [4:0] dest,
                                              input logic [31:0] res, input logic ertn, input logic ex);
        logic [31:0] pc = $urandom;
        logic [31:0] inst = $urandom;
        logic [31:0] wmask = $urandom;
        logic [31:0] wvalue = $urandom;
        logic [31:0] wrong_addr = $urandom;
        logic [13:0] csr_num = 14'($urandom);
        logic [8:0]  esub = 9'($urandom);
        logic [5:0]  ecode = 6'($urandom);
        logic        csr_we = 1'($urandom);
        logic        csr_re = 1'($urandom);
        logic        syscall = 1'($urandom);
        logic        ale = 1'($urandom);
        logic        adef = 1'($urandom);
        return {gr_we, rfm, mt, low2, dest, pc, inst, res, csr_we, csr_re, csr_num, wmask, wvalue,
                ertn, syscall, wrong_addr, ale, adef, ex, esub, ecode};
    endfunction

    // WB payload: ex_mem fields without res_from_mem/mem_type/addr_low2, result replaced.
    function automatic logic [233:0] exp_wb(input logic [239:0] b, input logic [31:0] fin);
        return {b[239], b[232:228], b[227:196], b[195:164], fin, b[131:0]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] mt, input logic [1:0] low2, input logic [31:0] rd);
        int unsigned sh;
        int unsigned v;
        sh = rd >> (8 * low2);
        case (mt)
            3'b000: begin v = sh % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'b001: begin v = sh % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'b100: v = sh % 256;
            3'b101: v = sh % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
        #2;
        total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin: got %b want 1", mem_allowin); end
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b want 0", mem_wb_valid); end
        total++; if (mem_ex !== 1'b0) begin bad++; $display("FAIL reset_mem_ex: got %b want 0", mem_ex); end
        total++; if (mem_ertn !== 1'b0) begin bad++; $display("FAIL reset_mem_ertn: got %b want 0", mem_ertn); end
        total++; if (id_bypass !== 1'b0) begin bad++; $display("FAIL reset_bypass: got %b want 0", id_bypass); end
        total++; if (id_ld_wait !== 1'b0) begin bad++; $display("FAIL reset_ld_wait: got %b want 0", id_ld_wait); end
        total++; if (dbg.cancel_cnt !== 2'd0) begin bad++; $display("FAIL reset_cancel: got %0d want 0", dbg.cancel_cnt); end
    endtask

    task automatic test_load_b();
        logic [239:0] b;
        logic [233:0] e;
        step;
        b = make_bus(1'b1, 1'b1, 3'b000, 2'd3, 5'd7, $urandom, 1'b0, 1'b0);
        e = exp_wb(b, ref_load(3'b000, 2'd3, 32'h80FF_1234));
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_bus = b;
        #2;
        total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL ldb_allowin: got %b want 1", mem_allowin); end
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL ldb_wait_valid: got %b want 0", mem_wb_valid); end
        total++; if (id_ld_wait !== 1'b1) begin bad++; $display("FAIL ldb_ld_wait: got %b want 1", id_ld_wait); end
        step;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL ldb_wait_valid2: got %b want 0", mem_wb_valid); end
        step;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234;
        #2;
        total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL ldb_ok_valid: got %b want 1", mem_wb_valid); end
        total++; if (wb_result !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldb_result: got %h want ffffff80", wb_result); end
        total++; if (mem_wb_bus !== e) begin bad++; $display("FAIL ldb_wb_bus: got %h want %h", mem_wb_bus, e); end
        total++; if (id_ld_wait !== 1'b0) begin bad++; $display("FAIL ldb_ld_wait_ok: got %b want 0", id_ld_wait); end
        step;
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL ldb_after: got %b want 0", mem_wb_valid); end
        total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL ldb_after_allowin: got %b want 1", mem_allowin); end
    endtask

    task automatic test_ldhu_hold();
        logic [239:0] b;
        logic [233:0] e;
        int hs = 0;
        step;
        b = make_bus(1'b1, 1'b1, 3'b101, 2'd2, 5'd9, $urandom, 1'b0, 1'b0);
        e = exp_wb(b, ref_load(3'b101, 2'd2, 32'h8765_4321));
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_bus = b;
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
        step;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8765_4321; wb_allowin = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #2;
            if (c < 4) begin
                total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL ldhu_hold_valid c=%0d: got %b want 1", c, mem_wb_valid); end
                total++; if (wb_result !== 32'h0000_8765) begin bad++; $display("FAIL ldhu_result c=%0d: got %h want 00008765", c, wb_result); end
            end
            if (c == 1) begin
                total++; if (dbg.buf_vld !== 1'b1) begin bad++; $display("FAIL ldhu_buf_vld: got %b want 1", dbg.buf_vld); end
                total++; if (mem_allowin !== 1'b0) begin bad++; $display("FAIL ldhu_stall_allowin: got %b want 0", mem_allowin); end
            end
            if (mem_wb_valid && wb_allowin) begin
                hs++;
                total++; if (mem_wb_bus !== e) begin bad++; $display("FAIL ldhu_wb_bus: got %h want %h", mem_wb_bus, e); end
            end
            step;
            data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
            wb_allowin = (c >= 2);
        end
        total++; if (hs != 1) begin bad++; $display("FAIL ldhu_handshakes: got %0d want 1", hs); end
        wb_allowin = 1'b1;
    endtask

    task automatic test_cancel();
        logic [239:0] b;
        logic [233:0] e;
        step;
        b = make_bus(1'b1, 1'b1, 3'b010, 2'd0, 5'd3, $urandom, 1'b0, 1'b0);
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_bus = b;
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0; wb_ex = 1'b1;
        step;
        wb_ex = 1'b0;
        #2;
        total++; if (dbg.cancel_cnt !== 2'd1) begin bad++; $display("FAIL cancel_inc: got %0d want 1", dbg.cancel_cnt); end
        total++; if (id_bypass !== 1'b0) begin bad++; $display("FAIL cancel_flushed: got %b want 0", id_bypass); end
        b = make_bus(1'b1, 1'b1, 3'b010, 2'd0, 5'd4, $urandom, 1'b0, 1'b0);
        e = exp_wb(b, ref_load(3'b010, 2'd0, 32'h1234_5678));
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1; ex_mem_bus = b;
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL cancel_discard: got %b want 0", mem_wb_valid); end
        total++; if (id_ld_wait !== 1'b1) begin bad++; $display("FAIL cancel_ld_wait: got %b want 1", id_ld_wait); end
        step;
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
        #2;
        total++; if (dbg.cancel_cnt !== 2'd0) begin bad++; $display("FAIL cancel_dec: got %0d want 0", dbg.cancel_cnt); end
        total++; if (dbg.state !== S_WAIT) begin bad++; $display("FAIL cancel_still_wait: got %0d want %0d", dbg.state, S_WAIT); end
        step;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        #2;
        total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL cancel_second_valid: got %b want 1", mem_wb_valid); end
        total++; if (wb_result !== 32'h1234_5678) begin bad++; $display("FAIL cancel_second_result: got %h want 12345678", wb_result); end
        total++; if (mem_wb_bus !== e) begin bad++; $display("FAIL cancel_wb_bus: got %h want %h", mem_wb_bus, e); end
        step;
        data_sram_data_ok = 1'b0;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL cancel_after: got %b want 0", mem_wb_valid); end
    endtask

    task automatic test_flush_dataok();
        step;
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1;
        ex_mem_bus = make_bus(1'b1, 1'b1, 3'b010, 2'd0, 5'd5, $urandom, 1'b0, 1'b0);
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = $urandom; ertn_flush = 1'b1;
        step;
        data_sram_data_ok = 1'b0; ertn_flush = 1'b0;
        #2;
        total++; if (dbg.cancel_cnt !== 2'd0) begin bad++; $display("FAIL flushok_cancel: got %0d want 0", dbg.cancel_cnt); end
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL flushok_valid: got %b want 0", mem_wb_valid); end
        total++; if (id_bypass !== 1'b0) begin bad++; $display("FAIL flushok_bypass: got %b want 0", id_bypass); end
        total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL flushok_allowin: got %b want 1", mem_allowin); end
    endtask

    task automatic test_back_to_back();
        logic [239:0] bq[6];
        logic [239:0] p;
        logic [54:0]  eid;
        step;
        for (int i = 0; i < 6; i++)
            bq[i] = make_bus(1'b1, 1'b0, 3'($urandom), 2'($urandom), 5'($urandom), $urandom, 1'b0, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                ex_mem_valid = 1'b1; ex_mem_req = 1'b0; ex_mem_bus = bq[i];
            end else begin
                ex_mem_valid = 1'b0;
            end
            #2;
            total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL b2b_allowin i=%0d: got %b want 1", i, mem_allowin); end
            if (i > 0) begin
                p = bq[i-1];
                eid = {1'b1, 1'b0, p[232:228], p[163:132], p[239], p[130], p[129:116]};
                total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid i=%0d: got %b want 1", i, mem_wb_valid); end
                total++; if (mem_wb_bus !== exp_wb(p, p[163:132])) begin bad++; $display("FAIL b2b_wb_bus i=%0d: got %h want %h", i, mem_wb_bus, exp_wb(p, p[163:132])); end
                total++; if (mem_id_bus !== eid) begin bad++; $display("FAIL b2b_id_bus i=%0d: got %h want %h", i, mem_id_bus, eid); end
            end
            step;
        end
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", mem_wb_valid); end
    endtask

    task automatic test_exc();
        step;
        ex_mem_valid = 1'b1; ex_mem_req = 1'b0;
        ex_mem_bus = make_bus(1'b1, 1'b0, 3'b000, 2'd0, 5'd1, $urandom, 1'b0, 1'b1);
        step;
        ex_mem_bus = make_bus(1'b1, 1'b0, 3'b000, 2'd0, 5'd2, $urandom, 1'b1, 1'b0);
        #2;
        total++; if (mem_ex !== 1'b1) begin bad++; $display("FAIL exc_mem_ex: got %b want 1", mem_ex); end
        total++; if (mem_ertn !== 1'b0) begin bad++; $display("FAIL exc_mem_ertn0: got %b want 0", mem_ertn); end
        total++; if (id_bypass !== 1'b0) begin bad++; $display("FAIL exc_bypass: got %b want 0", id_bypass); end
        step;
        ex_mem_valid = 1'b0;
        #2;
        total++; if (mem_ertn !== 1'b1) begin bad++; $display("FAIL ertn_mem_ertn: got %b want 1", mem_ertn); end
        total++; if (mem_ex !== 1'b0) begin bad++; $display("FAIL ertn_mem_ex: got %b want 0", mem_ex); end
        total++; if (id_bypass !== 1'b1) begin bad++; $display("FAIL ertn_bypass: got %b want 1", id_bypass); end
        step;
        #2;
        total++; if (mem_ertn !== 1'b0) begin bad++; $display("FAIL exc_drain: got %b want 0", mem_ertn); end
    endtask

    task automatic test_random();
        logic [239:0] b;
        logic [233:0] e;
        logic [31:0]  rd;
        logic [31:0]  res;
        logic [2:0]   mt;
        logic [1:0]   low2;
        logic         rfm;
        logic         req;
        int           kind;
        int           lat;
        int           stall;
        bit           done;
        for (int n = 0; n < 40; n++) begin
            step;
            data_sram_data_ok = 1'b0; wb_allowin = 1'b1;
            kind = $urandom_range(0, 6);
            rfm = (kind <= 4);
            req = (kind != 5);
            low2 = 2'($urandom);
            case (kind)
                0: mt = 3'b000;
                1: begin mt = 3'b001; low2 = {low2[0], 1'b0}; end
                2: begin mt = 3'b010; low2 = 2'd0; end
                3: mt = 3'b100;
                4: begin mt = 3'b101; low2 = {low2[0], 1'b0}; end
                default: mt = 3'($urandom);
            endcase
            rd = $urandom;
            res = $urandom;
            b = make_bus(1'($urandom), rfm, mt, low2, 5'($urandom), res, 1'b0, 1'b0);
            exp_q.push_back(exp_wb(b, rfm ? ref_load(mt, low2, rd) : res));
            ex_mem_valid = 1'b1; ex_mem_req = req; ex_mem_bus = b;
            step;
            ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
            if (req) begin
                lat = $urandom_range(0, 3);
                for (int k = 0; k < lat; k++) begin
                    #2;
                    total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL rand_wait n=%0d: got %b want 0", n, mem_wb_valid); end
                    step;
                end
                data_sram_data_ok = 1'b1; data_sram_rdata = rd;
            end
            stall = $urandom_range(0, 2);
            wb_allowin = (stall == 0);
            done = 1'b0;
            for (int k = 0; k < 8 && !done; k++) begin
                #2;
                total++; if (mem_wb_valid !== 1'b1) begin bad++; $display("FAIL rand_valid n=%0d: got %b want 1", n, mem_wb_valid); end
                if (mem_wb_valid && wb_allowin) begin
                    e = exp_q.pop_front();
                    total++; if (mem_wb_bus !== e) begin bad++; $display("FAIL rand_wb_bus n=%0d: got %h want %h", n, mem_wb_bus, e); end
                    done = 1'b1;
                end else begin
                    step;
                    data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
                    stall--;
                    wb_allowin = (stall <= 0);
                end
            end
            if (!done) begin
                bad++; total++;
                $display("FAIL rand_timeout n=%0d: got no handshake want one", n);
                void'(exp_q.pop_front());
            end
        end
        step;
        data_sram_data_ok = 1'b0; wb_allowin = 1'b1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_queue: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        step;
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1;
        ex_mem_bus = make_bus(1'b1, 1'b1, 3'b010, 2'd0, 5'd6, $urandom, 1'b0, 1'b0);
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0; wb_ex = 1'b1;
        step;
        wb_ex = 1'b0;
        ex_mem_valid = 1'b1; ex_mem_req = 1'b1;
        ex_mem_bus = make_bus(1'b1, 1'b1, 3'b010, 2'd0, 5'd8, $urandom, 1'b0, 1'b0);
        step;
        ex_mem_valid = 1'b0; ex_mem_req = 1'b0;
        #2;
        total++; if (dbg.cancel_cnt !== 2'd1) begin bad++; $display("FAIL rmw_pre_cancel: got %0d want 1", dbg.cancel_cnt); end
        reset = 1'b1;
        step;
        reset = 1'b0;
        #2;
        total++; if (mem_wb_valid !== 1'b0) begin bad++; $display("FAIL rmw_wb_valid: got %b want 0", mem_wb_valid); end
        total++; if (mem_allowin !== 1'b1) begin bad++; $display("FAIL rmw_allowin: got %b want 1", mem_allowin); end
        total++; if (dbg.cancel_cnt !== 2'd0) begin bad++; $display("FAIL rmw_cancel: got %0d want 0", dbg.cancel_cnt); end
        total++; if (id_bypass !== 1'b0) begin bad++; $display("FAIL rmw_valid: got %b want 0", id_bypass); end
    endtask

    initial begin
        reset = 1'b1;
        ex_mem_valid = 1'b0;
        ex_mem_bus = '0;
        ex_mem_req = 1'b0;
        wb_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        wb_ex = 1'b0;
        ertn_flush = 1'b0;
        test_reset();
        test_load_b();
        test_ldhu_hold();
        test_cancel();
        test_flush_dataok();
        test_back_to_back();
        test_exc();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
